serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing a - b - bin, LSB first, one bit per clock. Each bit uses a registered full-subtractor cell (difference = x^y^borrow, borrow-out = (~x&y)|(~(x^y)&borrow)), the subtracting counterpart of the team's full-adder cells. It sits beside the combinational adders in the arithmetic datapath where area matters more than latency. A start/busy/done handshake frames each operation.

Parameters:
N, 8, operand and result width in bits; legal range N >= 2.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
start  input  1  request to begin an operation; sampled only in IDLE or DONE.
a  input  N  minuend, unsigned or two's complement; latched when start is accepted.
b  input  N  subtrahend; latched when start is accepted.
bin  input  1  borrow-in; latched when start is accepted.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse; diff, bout and ovf are valid from this cycle on.
diff  output  N  result a - b - bin, modulo 2^N.
bout  output  1  final borrow-out; equals 1 iff unsigned a < b + bin.
ovf  output  1  signed overflow: (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow flop and bit counter cleared. Reset wins over every other event, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b and bin into shift registers and the borrow flop, clears the counter to 0, and moves to RUN. start=0 stays in IDLE.
- RUN: busy=1. Each edge does the following:
  - processes the bit at shift position 0 with the current borrow;
  - shifts the difference bit into diff from the MSB side, so bit i lands at diff[i] after N shifts;
  - updates the borrow flop and increments the counter.
  - On the edge that processes bit N-1, the FSM moves to DONE, bout takes the final borrow, and ovf is computed from the latched a[N-1], b[N-1] and the final diff[N-1].
- Latency: start is sampled at edge E0; bits 0..N-1 are processed at edges E1..EN; done=1 and busy=0 in the cycle following EN. Total: N cycles from accept to done.
- In RUN, start is ignored and the a, b and bin inputs are don't-care.
- DONE: lasts exactly one cycle with done=1.
  - start=1 in DONE is accepted as in IDLE: back-to-back operation with no idle gap, and busy rises the next cycle.
  - Otherwise the FSM returns to IDLE.
- diff, bout and ovf hold their values from DONE until the next accepted start. They are not defined during RUN; the verifier checks them only at done.
- Counter width is clog2(N). No other wrap-around exists; the counter is reloaded on every accept.
- Each per-bit step must match the full-subtractor truth table (x, y, borrow -> d, bo):
  000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.

Test Plan:
- N=8, a=0x05, b=0x03, bin=0, start pulse: done exactly 8 cycles after accept; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
- a=0x03, b=0x05, bin=0: diff=0xFE, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0: diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF: diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1: diff=0xFF, bout=1, ovf=0.
- Hold start high continuously with operands changing each cycle:
  - pulses while busy are ignored;
  - start in the DONE cycle launches the next operation, and done pulses every N+1 cycles;
  - results match the operands latched at each accept.
- Assert rst_n=0 for one edge at bit 4 of a RUN: all outputs 0 and state IDLE on the next cycle; no done pulse; a fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Framed by a start/busy/done handshake; results hold from done until the next accepted start.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic [1:0]   fsm_state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic          a_msb;
    logic          b_msb;
    logic          x;
    logic          y;
    logic          d;
    logic          bo;

    assign fsm_state = state;

    // Full-subtractor cell on the bit currently at shift position 0.
    always_comb begin
        x  = a_sh[0];
        y  = b_sh[0];
        d  = x ^ y ^ borrow;
        bo = (~x & y) | (~(x ^ y) & borrow);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    diff   <= {d, diff[N-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bo;
                    cnt    <= cnt + 1'b1;
                    // Last bit: d is the final diff MSB, bo the final borrow.
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bout  <= bo;
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [1:0]   fsm_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [N+1:0] ref_sub(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                             input logic rbin);
        int          full;
        logic [N-1:0] rd;
        logic        rbo;
        logic        rov;
        full = int'(ra) - int'(rb) - int'(rbin);
        rd   = full[N-1:0];
        rbo  = int'(ra) < (int'(rb) + int'(rbin));
        rov  = (ra[N-1] != rb[N-1]) && (rd[N-1] != ra[N-1]);
        return {rov, rbo, rd};
    endfunction

    // Cycle-level model: an accepted start keeps busy for N cycles, then done for one.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_cnt  = 0;
    logic [N+1:0] m_pend = '0;
    logic [N+1:0] m_res  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_res  = '0;
        end else if (!m_busy && start) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_cnt  = N;
            m_pend = ref_sub(a, b, bin);
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("state", fsm_state, m_busy ? 2'd1 : (m_done ? 2'd2 : 2'd0));
            if (!m_busy) begin
                chk("diff", diff, m_res[N-1:0]);
                chk("bout", bout, m_res[N]);
                chk("ovf", ovf, m_res[N+1]);
            end
        end
    end

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                          input logic [N-1:0] ed, input logic eb, input logic eo);
        int cyc;
        int bcnt;
        chk("model_pin", ref_sub(ta, tb, tbin), {eo, eb, ed});
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb;
        bin = tbin;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom_range(0, 255));
        b = N'($urandom_range(0, 255));
        bin = 1'($urandom_range(0, 1));
        cyc = 0;
        bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, N);
        chk("busy_cycles", bcnt, N);
        chk("op_diff", diff, ed);
        chk("op_bout", bout, eb);
        chk("op_ovf", ovf, eo);
        @(negedge clk);
        chk("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        int last;
        int ndone;
        int late_done;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, '0);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_state", fsm_state, 2'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);

        // start held high with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        last = -1;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("b2b_gap", i - last, N + 1);
                last = i;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 5);
        repeat (12) @(negedge clk);

        // reset asserted for one edge while bit 4 is being processed
        start = 1'b1;
        a = 8'h9C;
        b = 8'h27;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_done", done, 1'b0);
        chk("midrun_rst_diff", diff, '0);
        chk("midrun_rst_bout", bout, 1'b0);
        chk("midrun_rst_ovf", ovf, 1'b0);
        chk("midrun_rst_state", fsm_state, 2'd0);
        late_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("no_done_after_rst", late_done, 0);
        run_op(8'h9C, 8'h27, 1'b0, 8'h75, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
